ps2_rx_fifo: RTL

Parametrised receive-only PS/2 device-to-host interface, successor to the single-byte keyboard receiver.
- Synchronises and deglitches PS2C/PS2D, then decodes 11-bit frames: start, 8 data bits LSB-first, odd parity, stop.
- Frames that check good are buffered in a DEPTH-entry show-ahead FIFO that the CPU pops with an active-low read strobe.
- Sticky parity, frame and overflow error flags, plus a frame timeout, make line faults visible to software instead of being silently dropped.

---
 rtl/ps2_rx_fifo.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - receive-only PS/2 interface with show-ahead byte FIFO and sticky error flags
//
// ps2_rx_filter: two-flop synchroniser plus run-length deglitcher for one PS/2 line.
//   clk, rst     system clock, asynchronous active-low reset
//   din          raw asynchronous line
//   dout         synchronised and filtered line, idles high
//
// ps2_rx_fifo: decodes start / 8 data LSB-first / odd parity / stop frames and
// buffers good bytes in a 2**AW entry FIFO.
//   clk, rst     system clock, asynchronous active-low reset
//   PS2C, PS2D   PS/2 clock and data lines (asynchronous, never driven)
//   rdn          active-low pop strobe, one entry per low cycle
//   clr_err      clears the sticky error flags
//   data         FIFO head byte, 8'h00 when empty
//   ready        FIFO non-empty
//   count        entries held, 0..DEPTH
//   parity_err   sticky, frame dropped for bad parity
//   frame_err    sticky, frame dropped for stop = 0 or timeout
//   overflow     sticky, good frame dropped because the FIFO was full

module ps2_rx_filter #(
  parameter int LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = (LEN < 2) ? 1 : $clog2(LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] run;

  // run counts consecutive synchronised samples that disagree with dout;
  // any agreeing sample restarts the count, so short glitches never pass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= 2'b11;
      run  <= '0;
      dout <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout) begin
        run <= '0;
      end else if (run == CW'(LEN - 1)) begin
        dout <= sync[1];
        run  <= '0;
      end else begin
        run <= run + CW'(1);
      end
    end
  end

endmodule

module ps2_rx_fifo #(
  parameter int AW          = 3,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          PS2C,
  input  logic          PS2D,
  input  logic          rdn,
  input  logic          clr_err,
  output logic [7:0]    data,
  output logic          ready,
  output logic [AW:0]   count,
  output logic          parity_err,
  output logic          frame_err,
  output logic          overflow
);

  localparam int          DEPTH = 1 << AW;
  localparam int          TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AW:0] FULL  = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------- inputs
  logic c_filt, d_filt, c_filt_d;
  logic fall;

  ps2_rx_filter #(.LEN(FILTER_LEN)) u_filt_c (
    .clk  (clk),
    .rst  (rst),
    .din  (PS2C),
    .dout (c_filt)
  );

  ps2_rx_filter #(.LEN(FILTER_LEN)) u_filt_d (
    .clk  (clk),
    .rst  (rst),
    .din  (PS2D),
    .dout (d_filt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) c_filt_d <= 1'b1;
    else      c_filt_d <= c_filt;
  end

  assign fall = c_filt_d & ~c_filt;

  // ------------------------------------------------------------------- FSM
  state_t        state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          expire;
  logic          push_req;
  logic          par_set;
  logic          frm_set;

  assign expire = (state != S_IDLE) && (tcnt == TLIM);

  // push_req / par_set / frm_set are one-cycle registered pulses. shreg is
  // the write data for push_req: it is only modified by DATA-state falls,
  // which cannot occur in the cycle following a stop-bit fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      bitcnt   <= 3'd0;
      shreg    <= 8'h00;
      par_bit  <= 1'b0;
      tcnt     <= '0;
      push_req <= 1'b0;
      par_set  <= 1'b0;
      frm_set  <= 1'b0;
    end else begin
      push_req <= 1'b0;
      par_set  <= 1'b0;
      frm_set  <= 1'b0;

      // Saturates at the limit so expiry holds until the FSM leaves the frame.
      if (state == S_IDLE || fall) tcnt <= '0;
      else if (tcnt != TLIM)       tcnt <= tcnt + TW'(1);

      // Expiry has priority: a fall landing on the expiry cycle is dropped.
      if (expire) begin
        state   <= S_IDLE;
        frm_set <= 1'b1;
      end else if (fall) begin
        case (state)
          S_IDLE: begin
            if (!d_filt) begin
              state  <= S_DATA;
              bitcnt <= 3'd0;
            end
          end
          S_DATA: begin
            shreg  <= {d_filt, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= d_filt;
            state   <= S_STOP;
          end
          S_STOP: begin
            state <= S_IDLE;
            if (!d_filt)                 frm_set  <= 1'b1;
            else if (^{shreg, par_bit})  push_req <= 1'b1;
            else                         par_set  <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // ------------------------------------------------------------------ FIFO
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_pop, do_push, ovf_set;

  assign do_pop  = !rdn && (cnt != '0);
  // A pop frees the slot in the same edge, so a full FIFO still accepts.
  assign do_push = push_req && ((cnt != FULL) || do_pop);
  assign ovf_set = push_req && (cnt == FULL) && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW + 1)'(1);
        2'b01:   cnt <= cnt - (AW + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign ready = (cnt != '0);
  assign count = cnt;
  assign data  = ready ? mem[rptr] : 8'h00;

  // ----------------------------------------------------------- error flags
  // A set pulse coinciding with clr_err leaves the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      parity_err <= par_set | (parity_err & ~clr_err);
      frame_err  <= frm_set | (frame_err  & ~clr_err);
      overflow   <= ovf_set | (overflow   & ~clr_err);
    end
  end

endmodule
